// File: rtl/vram_mem_arbiter.sv
// Arbitrates one 64-bit memory port between sprite VRAM row bursts (ESRD/ESWR)
// and single-beat CPU accesses, with a one-shot fairness flag for the CPU.
module vram_mem_arbiter #(
  parameter int unsigned BEATS  = 128,
  parameter int unsigned ADDR_W = 18
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] ESADDR,
  input  logic [63:0]       ESDATA,
  input  logic              ESRD,
  input  logic              ESWR,
  output logic [63:0]       ESQ,
  output logic              ESTE,
  input  logic [ADDR_W-1:0] CPU_A,
  input  logic [63:0]       CPU_D,
  input  logic [7:0]        CPU_BE,
  input  logic              CPU_RD,
  input  logic              CPU_WR,
  output logic [63:0]       CPU_Q,
  output logic              CPU_ACK,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [63:0]       MEM_D,
  output logic [7:0]        MEM_BE,
  input  logic [63:0]       MEM_Q,
  input  logic              MEM_ACK,
  output logic              BUSY
);

  localparam int unsigned BW = $clog2(BEATS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XFER_RD,
    ST_XFER_WR,
    ST_CPU_RD,
    ST_CPU_WR
  } state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic                armed_q, armed_d;
  logic                prio_q, prio_d;
  logic [ADDR_W-1:0]   caddr_q, caddr_d;
  logic [63:0]         cdata_q, cdata_d;
  logic [7:0]          cbe_q, cbe_d;
  logic [63:0]         cpu_q_q, cpu_q_d;
  logic                cpu_ack_q, cpu_ack_d;

  logic xfer_req;
  logic cpu_req;
  logic xfer_act;
  logic last_beat;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      armed_q   <= 1'b1;
      prio_q    <= 1'b0;
      caddr_q   <= '0;
      cdata_q   <= '0;
      cbe_q     <= '0;
      cpu_q_q   <= '0;
      cpu_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      armed_q   <= armed_d;
      prio_q    <= prio_d;
      caddr_q   <= caddr_d;
      cdata_q   <= cdata_d;
      cbe_q     <= cbe_d;
      cpu_q_q   <= cpu_q_d;
      cpu_ack_q <= cpu_ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    armed_d   = armed_q;
    prio_d    = prio_q;
    caddr_d   = caddr_q;
    cdata_d   = cdata_q;
    cbe_d     = cbe_q;
    cpu_q_d   = cpu_q_q;
    cpu_ack_d = 1'b0;
    xfer_req  = armed_q & (ESRD | ESWR);
    // A request still seen during the CPU_ACK cycle belongs to the access just finished.
    cpu_req   = (CPU_RD | CPU_WR) & ~cpu_ack_q;
    xfer_act  = (state_q == ST_XFER_RD) ? ESRD : ESWR;
    last_beat = MEM_ACK && (beat_q == BW'(BEATS - 1));
    unique case (state_q)
      ST_IDLE: begin
        if (xfer_req && !(cpu_req && prio_q)) begin
          state_d = ESRD ? ST_XFER_RD : ST_XFER_WR;
          beat_d  = '0;
        end else if (cpu_req) begin
          state_d = CPU_RD ? ST_CPU_RD : ST_CPU_WR;
          caddr_d = CPU_A & {{(ADDR_W-2){1'b1}}, 2'b00};
          cdata_d = CPU_D;
          cbe_d   = CPU_BE;
          prio_d  = 1'b0;
        end
      end
      ST_XFER_RD, ST_XFER_WR: begin
        if (MEM_ACK) beat_d = beat_q + BW'(1);
        if (last_beat || !xfer_act) begin
          state_d = ST_IDLE;
          beat_d  = '0;
          if (last_beat) armed_d = 1'b0;
          if (CPU_RD || CPU_WR) prio_d = 1'b1;
        end
      end
      ST_CPU_RD, ST_CPU_WR: begin
        if (MEM_ACK) begin
          cpu_ack_d = 1'b1;
          if (state_q == ST_CPU_RD) cpu_q_d = MEM_Q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Re-arming only once both strobes are low stops a held request replaying a finished row.
    if (!ESRD && !ESWR) armed_d = 1'b1;
  end

  always_comb begin
    MEM_REQ  = 1'b0;
    MEM_WE   = 1'b0;
    MEM_ADDR = '0;
    MEM_BE   = '0;
    MEM_D    = '0;
    ESTE     = 1'b0;
    unique case (state_q)
      ST_XFER_RD: begin
        MEM_REQ  = 1'b1;
        MEM_ADDR = ESADDR + ADDR_W'({beat_q, 2'b00});
        MEM_BE   = '1;
        ESTE     = MEM_ACK;
      end
      ST_XFER_WR: begin
        MEM_REQ  = 1'b1;
        MEM_WE   = 1'b1;
        MEM_ADDR = ESADDR + ADDR_W'({beat_q, 2'b00});
        MEM_BE   = '1;
        MEM_D    = ESDATA;
        ESTE     = MEM_ACK;
      end
      ST_CPU_RD: begin
        MEM_REQ  = 1'b1;
        MEM_ADDR = caddr_q;
        MEM_BE   = '1;
      end
      ST_CPU_WR: begin
        MEM_REQ  = 1'b1;
        MEM_WE   = 1'b1;
        MEM_ADDR = caddr_q;
        MEM_BE   = cbe_q;
        MEM_D    = cdata_q;
      end
      default: ;
    endcase
  end

  assign BUSY    = (state_q != ST_IDLE);
  assign ESQ     = MEM_Q;
  assign CPU_Q   = cpu_q_q;
  assign CPU_ACK = cpu_ack_q;

endmodule

// File: tb/tb_vram_mem_arbiter.sv
// Bench for vram_mem_arbiter: directed row/CPU/reset scenarios with literal
// expectations, then randomized traffic checked every cycle against a behavioural model.
module tb_vram_mem_arbiter;

  localparam int unsigned BEATS  = 128;
  localparam int unsigned ADDR_W = 18;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b1;
  logic [17:0]       ESADDR = '0;
  logic [63:0]       ESDATA = '0;
  logic              ESRD = 1'b0, ESWR = 1'b0;
  logic [63:0]       ESQ;
  logic              ESTE;
  logic [17:0]       CPU_A = '0;
  logic [63:0]       CPU_D = '0;
  logic [7:0]        CPU_BE = '0;
  logic              CPU_RD = 1'b0, CPU_WR = 1'b0;
  logic [63:0]       CPU_Q;
  logic              CPU_ACK;
  logic              MEM_REQ, MEM_WE;
  logic [17:0]       MEM_ADDR;
  logic [63:0]       MEM_D;
  logic [7:0]        MEM_BE;
  logic [63:0]       MEM_Q = '0;
  logic              MEM_ACK = 1'b0;
  logic              BUSY;

  int checks = 0;
  int errors = 0;
  int ack_mode = 0;   // 0 never, 1 every cycle, 2 every 3rd cycle, 3 random
  int cyc = 0;
  bit cmp_on = 0;

  // Model: owner 0 none, 1 row read, 2 row write, 3 cpu read, 4 cpu write
  int          m_mode = 0;
  int          m_beat = 0;
  bit          m_armed = 1;
  bit          m_prio = 0;
  bit          m_cack = 0;
  logic [63:0] m_cq = '0;
  logic [63:0] m_cd = '0;
  logic [17:0] m_ca = '0;
  logic [7:0]  m_cbe = '0;

  vram_mem_arbiter #(.BEATS(BEATS), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ESADDR(ESADDR), .ESDATA(ESDATA), .ESRD(ESRD), .ESWR(ESWR),
    .ESQ(ESQ), .ESTE(ESTE),
    .CPU_A(CPU_A), .CPU_D(CPU_D), .CPU_BE(CPU_BE), .CPU_RD(CPU_RD), .CPU_WR(CPU_WR),
    .CPU_Q(CPU_Q), .CPU_ACK(CPU_ACK),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_D(MEM_D),
    .MEM_BE(MEM_BE), .MEM_Q(MEM_Q), .MEM_ACK(MEM_ACK), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_beat = 0; m_armed = 1; m_prio = 0; m_cack = 0;
    m_cq = '0; m_cd = '0; m_ca = '0; m_cbe = '0;
  endtask

  task automatic model_step();
    bit cpu_want, row_want, done, held;
    cpu_want = (CPU_RD || CPU_WR) && !m_cack;
    m_cack = 0;
    if (m_mode == 0) begin
      row_want = m_armed && (ESRD || ESWR);
      if (row_want && !(cpu_want && m_prio)) begin
        m_mode = ESRD ? 1 : 2;
        m_beat = 0;
      end else if (cpu_want) begin
        m_mode = CPU_RD ? 3 : 4;
        m_ca = CPU_A & 18'h3FFFC;
        m_cd = CPU_D;
        m_cbe = CPU_BE;
        m_prio = 0;
      end
    end else if (m_mode <= 2) begin
      held = (m_mode == 1) ? ESRD : ESWR;
      if (MEM_ACK) m_beat = m_beat + 1;
      done = (m_beat == BEATS);
      if (done || !held) begin
        if (done) m_armed = 0;
        if (CPU_RD || CPU_WR) m_prio = 1;
        m_mode = 0;
        m_beat = 0;
      end
    end else if (MEM_ACK) begin
      m_cack = 1;
      if (m_mode == 3) m_cq = MEM_Q;
      m_mode = 0;
    end
    if (!ESRD && !ESWR) m_armed = 1;
  endtask

  initial forever begin
    @(posedge CLK or negedge RST_N);
    if (!RST_N) model_reset();
    else model_step();
  end

  task automatic compare_all();
    logic [17:0] ea;
    logic [63:0] ed;
    logic [7:0]  eb;
    bit          row;
    row = (m_mode == 1) || (m_mode == 2);
    ea = '0; ed = '0; eb = '0;
    if (row) begin
      ea = ESADDR + 18'(4 * m_beat);
      eb = 8'hFF;
      if (m_mode == 2) ed = ESDATA;
    end else if (m_mode == 3) begin
      ea = m_ca; eb = 8'hFF;
    end else if (m_mode == 4) begin
      ea = m_ca; eb = m_cbe; ed = m_cd;
    end
    chk("BUSY", 64'(BUSY), 64'(m_mode != 0));
    chk("MEM_REQ", 64'(MEM_REQ), 64'(m_mode != 0));
    chk("MEM_WE", 64'(MEM_WE), 64'(m_mode == 2 || m_mode == 4));
    chk("MEM_ADDR", 64'(MEM_ADDR), 64'(ea));
    chk("MEM_BE", 64'(MEM_BE), 64'(eb));
    chk("MEM_D", MEM_D, ed);
    chk("ESTE", 64'(ESTE), 64'(MEM_ACK && row));
    chk("ESQ", ESQ, MEM_Q);
    chk("CPU_ACK", 64'(CPU_ACK), 64'(m_cack));
    chk("CPU_Q", CPU_Q, m_cq);
  endtask

  initial forever begin
    @(negedge CLK);
    if (cmp_on && RST_N) compare_all();
  end

  // Memory side and row write data
  initial forever begin
    @(posedge CLK);
    #1;
    cyc++;
    MEM_Q  = {$urandom, $urandom};
    ESDATA = {$urandom, $urandom};
    case (ack_mode)
      0:       MEM_ACK = 1'b0;
      1:       MEM_ACK = 1'b1;
      2:       MEM_ACK = (cyc % 3 == 0);
      default: MEM_ACK = ($urandom_range(0, 2) != 0);
    endcase
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic es_random();
    for (int e = 0; e < 30; e++) begin
      int sel;
      sel = $urandom_range(0, 3);
      ESADDR = {9'($urandom_range(0, 511)), 9'd0};
      ESRD = (sel != 1);
      ESWR = (sel != 0);
      wait_cyc($urandom_range(5, 400));
      ESRD = 1'b0;
      ESWR = 1'b0;
      wait_cyc($urandom_range(1, 4));
    end
  endtask

  task automatic cpu_random();
    for (int t = 0; t < 60; t++) begin
      bit got;
      int op;
      got = 0;
      wait_cyc($urandom_range(1, 40));
      CPU_A  = 18'($urandom);
      CPU_D  = {$urandom, $urandom};
      CPU_BE = 8'($urandom);
      op = $urandom_range(0, 8);
      CPU_RD = (op < 4) || (op == 8);
      CPU_WR = (op >= 4);
      for (int k = 0; k < 3000 && !got; k++) begin
        wait_cyc(1);
        if (CPU_ACK) got = 1;
      end
      CPU_RD = 1'b0;
      CPU_WR = 1'b0;
      chk("cpu_ack_wait", 64'(got), 64'd1);
    end
  endtask

  initial begin
    int n, fa, la;
    bit got;
    #3 RST_N = 1'b0;
    cmp_on = 1;
    #10;
    chk("rst_BUSY", 64'(BUSY), 64'd0);
    chk("rst_MEM_REQ", 64'(MEM_REQ), 64'd0);
    chk("rst_MEM_ADDR", 64'(MEM_ADDR), 64'd0);
    chk("rst_MEM_BE", 64'(MEM_BE), 64'd0);
    chk("rst_CPU_ACK", 64'(CPU_ACK), 64'd0);
    chk("rst_CPU_Q", CPU_Q, 64'd0);
    #9 RST_N = 1'b1;
    wait_cyc(2);

    // Row read, ack every cycle, request held well past the row
    ack_mode = 1; ESADDR = 18'h00A00; ESRD = 1'b1;
    n = 0; fa = 0; la = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (ESTE) begin
        if (n == 0) fa = int'(MEM_ADDR);
        la = int'(MEM_ADDR);
        n++;
      end
    end
    chk("t1_beats", 64'(n), 64'd128);
    chk("t1_first_addr", 64'(fa), 64'h0A00);
    chk("t1_last_addr", 64'(la), 64'h0BFC);
    chk("t1_req_off", 64'(MEM_REQ), 64'd0);
    wait_cyc(1);
    ESRD = 1'b0; ack_mode = 0;
    wait_cyc(2);

    // Row write, ack every third cycle
    ack_mode = 2; ESADDR = 18'h01200; ESWR = 1'b1;
    n = 0; fa = 0;
    for (int k = 0; k < 500 && n < 128; k++) begin
      @(negedge CLK);
      if (ESTE) begin
        if (n == 0) fa = int'(MEM_ADDR);
        n++;
      end
    end
    chk("t2_beats", 64'(n), 64'd128);
    chk("t2_first_addr", 64'(fa), 64'h1200);
    wait_cyc(1);
    ESWR = 1'b0; ack_mode = 0;
    wait_cyc(2);

    // CPU byte-masked write
    CPU_A = 18'h00104; CPU_D = 64'h1122334455667788; CPU_BE = 8'h0F; CPU_WR = 1'b1;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge CLK);
      if (MEM_REQ) got = 1;
    end
    chk("t3_req", 64'(got), 64'd1);
    chk("t3_addr", 64'(MEM_ADDR), 64'h104);
    chk("t3_be", 64'(MEM_BE), 64'h0F);
    chk("t3_we", 64'(MEM_WE), 64'd1);
    chk("t3_data", MEM_D, 64'h1122334455667788);
    ack_mode = 1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      wait_cyc(1);
      if (CPU_ACK) begin n++; CPU_WR = 1'b0; end
    end
    chk("t3_acks", 64'(n), 64'd1);
    ack_mode = 0;
    wait_cyc(2);

    // Simultaneous row read and CPU read: row first
    ack_mode = 1; ESADDR = 18'h02000; ESRD = 1'b1; CPU_RD = 1'b1; CPU_A = 18'h00300;
    n = 0; la = -1; got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge CLK);
      if (ESTE) n++;
      if (CPU_ACK) begin got = 1; la = n; end
    end
    chk("t4_beats_before_cpu", 64'(la), 64'd128);
    wait_cyc(1);
    CPU_RD = 1'b0; ESRD = 1'b0; ack_mode = 0;
    wait_cyc(2);

    // Abort after 40 beats, then restart from beat 0
    ack_mode = 1; ESADDR = 18'h04000; ESRD = 1'b1;
    n = 0;
    for (int k = 0; k < 100 && n < 40; k++) begin
      @(negedge CLK);
      if (ESTE) n++;
    end
    wait_cyc(1);
    ESRD = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("t5_req_dropped", 64'(MEM_REQ), 64'd0);
    chk("t5_idle", 64'(BUSY), 64'd0);
    wait_cyc(1);
    ESRD = 1'b1;
    got = 0; fa = -1;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge CLK);
      if (ESTE) begin got = 1; fa = int'(MEM_ADDR); end
    end
    chk("t5_restart_addr", 64'(fa), 64'h4000);
    wait_cyc(1);
    ESRD = 1'b0; ack_mode = 0;
    wait_cyc(2);

    // Reset during beat 70 of a row write
    ack_mode = 1; ESADDR = 18'h06000; ESWR = 1'b1;
    n = 0;
    for (int k = 0; k < 200 && n < 70; k++) begin
      @(negedge CLK);
      if (ESTE) n++;
    end
    #2 RST_N = 1'b0;
    #1;
    chk("t6_BUSY", 64'(BUSY), 64'd0);
    chk("t6_MEM_REQ", 64'(MEM_REQ), 64'd0);
    chk("t6_MEM_WE", 64'(MEM_WE), 64'd0);
    chk("t6_MEM_ADDR", 64'(MEM_ADDR), 64'd0);
    chk("t6_MEM_BE", 64'(MEM_BE), 64'd0);
    chk("t6_MEM_D", MEM_D, 64'd0);
    chk("t6_ESTE", 64'(ESTE), 64'd0);
    ESWR = 1'b0; ack_mode = 0;
    @(negedge CLK);
    #2 RST_N = 1'b1;
    @(negedge CLK);
    chk("t6_idle_after", 64'(BUSY), 64'd0);
    wait_cyc(1);

    // Randomized traffic from both requesters
    ack_mode = 3;
    fork
      es_random();
      cpu_random();
    join
    ack_mode = 0;
    wait_cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
